risc16ba_mem_arbiter: RTL and testbench

Single-port memory arbiter and MMIO decoder for the risc16ba core. Shares one synchronous 32K×16 SRAM among the instruction-fetch port, the data port and a host loader/dump port used for image load and frame-buffer dump (0xc000–0xffff). It decodes the LED registers at 0x200/0x202 and raises a stall to the core whenever a CPU request is not granted.

---
 rtl/risc16ba_mem_pkg.sv | 19 +
 rtl/risc16ba_led_mmio.sv | 32 +++
 rtl/risc16ba_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_risc16ba_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16ba_mem_pkg.sv
// Shared types and MMIO addresses for the risc16ba memory arbiter.
package risc16ba_mem_pkg;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_I,
        OWN_D,
        OWN_H,
        OWN_MMIO
    } owner_t;

    localparam logic [15:0] LED_ADDR0 = 16'h0200;
    localparam logic [15:0] LED_ADDR1 = 16'h0202;

    function automatic logic is_led_addr(input logic [15:0] addr);
        return (addr[15:1] == LED_ADDR0[15:1]) || (addr[15:1] == LED_ADDR1[15:1]);
    endfunction

endpackage

// File: rtl/risc16ba_led_mmio.sv
// LED register bank: three byte registers behind the 0x200/0x202 MMIO words.
module risc16ba_led_mmio (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  logic        sel_i,
    input  logic [1:0]  we_i,
    input  logic [15:0] wdata_i,
    output logic [23:0] led_o,
    output logic [15:0] rdata_o
);

    logic [23:0] led_q;

    // sel_i low selects 0x200 {led_1, led_0}; high selects 0x202 {-, led_2}
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else if (wr_i) begin
            if (!sel_i) begin
                if (we_i[1]) led_q[15:8] <= wdata_i[15:8];
                if (we_i[0]) led_q[7:0]  <= wdata_i[7:0];
            end else if (we_i[0]) begin
                led_q[23:16] <= wdata_i[7:0];
            end
        end
    end

    assign led_o   = led_q;
    assign rdata_o = sel_i ? {8'h00, led_q[23:16]} : led_q[15:0];

endmodule

// File: rtl/risc16ba_mem_arbiter.sv
// Single-port SRAM arbiter (data > instr > host, host aging override) with LED MMIO.
module risc16ba_mem_arbiter
    import risc16ba_mem_pkg::*;
#(
    parameter int unsigned HOST_MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic [15:0] i_rdata,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic [15:0] d_rdata,
    output logic        d_rvalid,
    input  logic        h_req,
    input  logic [1:0]  h_we,
    input  logic [15:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_gnt,
    output logic [15:0] h_rdata,
    output logic        h_rvalid,
    output logic        m_en,
    output logic [1:0]  m_we,
    output logic [14:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic [23:0] led,
    output logic        cpu_stall
);

    logic        d_mmio, d_sram, h_force, mmio_gnt;
    owner_t      win;
    owner_t      sram_own_q, sram_own_d;
    owner_t      mmio_own_q, mmio_own_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] i_rdata_q, d_rdata_q, h_rdata_q;
    logic [15:0] mmio_rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[0], h_addr[0]};

    assign d_mmio   = d_req && is_led_addr(d_addr);
    assign d_sram   = d_req && !d_mmio;
    assign h_force  = h_req && (wait_q == 8'(HOST_MAX_WAIT));
    assign mmio_gnt = d_mmio && !rst;

    always_comb begin
        win = OWN_NONE;
        if (!rst) begin
            if (h_force)     win = OWN_H;
            else if (d_sram) win = OWN_D;
            else if (i_req)  win = OWN_I;
            else if (h_req)  win = OWN_H;
        end
    end

    assign i_gnt     = (win == OWN_I);
    assign h_gnt     = (win == OWN_H);
    assign d_gnt     = (win == OWN_D) || mmio_gnt;
    assign cpu_stall = (i_req && !i_gnt) || (d_req && !d_gnt);

    always_comb begin
        m_en    = (win != OWN_NONE);
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        unique case (win)
            OWN_I: m_addr = i_addr[15:1];
            OWN_D: begin
                m_we    = d_we;
                m_addr  = d_addr[15:1];
                m_wdata = d_wdata;
            end
            OWN_H: begin
                m_we    = h_we;
                m_addr  = h_addr[15:1];
                m_wdata = h_wdata;
            end
            default: ;
        endcase
    end

    // An MMIO read may complete alongside an SRAM read, so it keeps its own tag
    always_comb begin
        sram_own_d = OWN_NONE;
        if (win == OWN_I || (win == OWN_D && d_we == 2'b00) || (win == OWN_H && h_we == 2'b00))
            sram_own_d = win;
        mmio_own_d = (mmio_gnt && d_we == 2'b00) ? OWN_MMIO : OWN_NONE;
        if (!h_req || h_gnt)
            wait_d = '0;
        else if (wait_q < 8'(HOST_MAX_WAIT))
            wait_d = wait_q + 8'd1;
        else
            wait_d = wait_q;
    end

    assign i_rvalid = !rst && (sram_own_q == OWN_I);
    assign h_rvalid = !rst && (sram_own_q == OWN_H);
    assign d_rvalid = !rst && (sram_own_q == OWN_D || mmio_own_q == OWN_MMIO);

    assign i_rdata = i_rvalid ? m_rdata : i_rdata_q;
    assign h_rdata = h_rvalid ? m_rdata : h_rdata_q;
    assign d_rdata = (!rst && sram_own_q == OWN_D) ? m_rdata : d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_own_q <= OWN_NONE;
            mmio_own_q <= OWN_NONE;
            wait_q     <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            sram_own_q <= sram_own_d;
            mmio_own_q <= mmio_own_d;
            wait_q     <= wait_d;
            if (sram_own_q == OWN_I) i_rdata_q <= m_rdata;
            if (sram_own_q == OWN_H) h_rdata_q <= m_rdata;
            // MMIO value is captured at grant so it is ready in d_rdata_q next cycle
            if (sram_own_q == OWN_D) d_rdata_q <= m_rdata;
            if (mmio_own_d == OWN_MMIO) d_rdata_q <= mmio_rdata;
        end
    end

    risc16ba_led_mmio u_led (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (mmio_gnt && d_we != 2'b00),
        .sel_i   (d_addr[1]),
        .we_i    (d_we),
        .wdata_i (d_wdata),
        .led_o   (led),
        .rdata_o (mmio_rdata)
    );

endmodule

// File: tb/tb_risc16ba_mem_arbiter.sv
// Directed + random bench for risc16ba_mem_arbiter against a transaction-level model.
module tb_risc16ba_mem_arbiter;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, h_req;
    logic [15:0] i_addr, d_addr, d_wdata, h_addr, h_wdata;
    logic [1:0]  d_we, h_we;
    logic        i_gnt, d_gnt, h_gnt, i_rvalid, d_rvalid, h_rvalid;
    logic [15:0] i_rdata, d_rdata, h_rdata;
    logic        m_en;
    logic [1:0]  m_we;
    logic [14:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata = '0;
    logic [23:0] led;
    logic        cpu_stall;

    risc16ba_mem_arbiter #(.HOST_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .led(led), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    // synchronous SRAM
    logic [15:0] sram [0:32767];
    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= sram[m_addr];
            if (m_we[1]) sram[m_addr][15:8] <= m_wdata[15:8];
            if (m_we[0]) sram[m_addr][7:0]  <= m_wdata[7:0];
        end
    end

    // reference model state
    logic [15:0] gold [0:32767];
    logic [7:0]  ledm [3];
    int          wait_m;
    bit          pv_i, pv_d, pv_h;
    logic [15:0] pd_i, pd_d, pd_h, last_i, last_d, last_h;
    bit          g_i, g_d, g_h;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void gold_write(input logic [15:0] baddr, input logic [1:0] we, input logic [15:0] wd);
        logic [15:0] w;
        w = gold[baddr[15:1]];
        if (we[1]) w[15:8] = wd[15:8];
        if (we[0]) w[7:0]  = wd[7:0];
        gold[baddr[15:1]] = w;
    endfunction

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 127));
        return 16'hC000 + 16'($urandom_range(0, 63));
    endfunction

    task automatic model_reset();
        wait_m = 0;
        pv_i = 0; pv_d = 0; pv_h = 0;
        last_i = '0; last_d = '0; last_h = '0;
        for (int k = 0; k < 3; k++) ledm[k] = '0;
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; h_req = 0;
        i_addr = '0; d_addr = '0; h_addr = '0;
        d_we = '0; h_we = '0; d_wdata = '0; h_wdata = '0;
    endtask

    // One cycle: inputs already driven; check at negedge, then advance the model.
    task automatic step();
        bit mmio, dsram, hforce, dg;
        int win;  // 0 none, 1 instr, 2 data, 3 host
        @(negedge clk);
        mmio   = d_req && (d_addr >= 16'h0200 && d_addr <= 16'h0203);
        dsram  = d_req && !mmio;
        hforce = h_req && (wait_m == MAXW);
        if (hforce)      win = 3;
        else if (dsram)  win = 2;
        else if (i_req)  win = 1;
        else if (h_req)  win = 3;
        else             win = 0;
        dg = (win == 2) || mmio;

        chk("i_gnt", i_gnt, win == 1);
        chk("d_gnt", d_gnt, dg);
        chk("h_gnt", h_gnt, win == 3);
        chk("cpu_stall", cpu_stall, (i_req && win != 1) || (d_req && !dg));
        chk("m_en", m_en, win != 0);
        if (win == 1) begin
            chk("m_addr_i", m_addr, i_addr[15:1]);
            chk("m_we_i", m_we, 2'b00);
        end else if (win == 2) begin
            chk("m_addr_d", m_addr, d_addr[15:1]);
            chk("m_we_d", m_we, d_we);
            if (d_we != 0) chk("m_wdata_d", m_wdata, d_wdata);
        end else if (win == 3) begin
            chk("m_addr_h", m_addr, h_addr[15:1]);
            chk("m_we_h", m_we, h_we);
            if (h_we != 0) chk("m_wdata_h", m_wdata, h_wdata);
        end
        chk("i_rvalid", i_rvalid, pv_i);
        chk("d_rvalid", d_rvalid, pv_d);
        chk("h_rvalid", h_rvalid, pv_h);
        chk("i_rdata", i_rdata, pv_i ? pd_i : last_i);
        chk("d_rdata", d_rdata, pv_d ? pd_d : last_d);
        chk("h_rdata", h_rdata, pv_h ? pd_h : last_h);
        chk("led", led, {ledm[2], ledm[1], ledm[0]});

        if (pv_i) last_i = pd_i;
        if (pv_d) last_d = pd_d;
        if (pv_h) last_h = pd_h;
        pv_i = 0; pv_d = 0; pv_h = 0;
        if (win == 1) begin
            pv_i = 1; pd_i = gold[i_addr[15:1]];
        end
        if (win == 2) begin
            if (d_we == 0) begin pv_d = 1; pd_d = gold[d_addr[15:1]]; end
            else gold_write(d_addr, d_we, d_wdata);
        end
        if (win == 3) begin
            if (h_we == 0) begin pv_h = 1; pd_h = gold[h_addr[15:1]]; end
            else gold_write(h_addr, h_we, h_wdata);
        end
        if (mmio) begin
            if (d_we == 0) begin
                pv_d = 1;
                pd_d = d_addr[1] ? {8'h00, ledm[2]} : {ledm[1], ledm[0]};
            end else if (!d_addr[1]) begin
                if (d_we[1]) ledm[1] = d_wdata[15:8];
                if (d_we[0]) ledm[0] = d_wdata[7:0];
            end else if (d_we[0]) begin
                ledm[2] = d_wdata[7:0];
            end
        end
        wait_m = (h_req && win != 3) ? ((wait_m < MAXW) ? wait_m + 1 : MAXW) : 0;
        g_i = (win == 1); g_d = dg; g_h = (win == 3);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit seen;
        // reset with all requesters active: nothing may be granted
        rst = 1;
        idle();
        i_req = 1; h_req = 1; h_we = 2'b11; h_addr = 16'h0000; h_wdata = 16'hDEAD;
        d_req = 1; d_we = 2'b11; d_addr = 16'h0200; d_wdata = 16'hFFFF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_gnt", i_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_h_gnt", h_gnt, 1'b0);
        chk("rst_m_en", m_en, 1'b0);
        chk("rst_m_we", m_we, 2'b00);
        chk("rst_led", led, 24'h0);
        chk("rst_rvalid", {i_rvalid, d_rvalid, h_rvalid}, 3'b000);
        @(posedge clk); #1;
        rst = 0;
        idle();

        // image load through the host port
        for (int w = 0; w < 64; w++) begin
            h_req = 1; h_we = 2'b11; h_addr = 16'(w * 2);
            h_wdata = (w == 0) ? 16'h1234 : 16'($urandom);
            step();
        end
        for (int w = 0; w < 32; w++) begin
            h_req = 1; h_we = 2'b11; h_addr = 16'hC000 + 16'(w * 2); h_wdata = 16'($urandom);
            step();
        end
        idle();
        step();

        // single fetch
        i_req = 1; i_addr = 16'h0000;
        step();
        idle();
        step();
        chk("fetch_word", i_rdata, 16'h1234);

        // data beats instruction, instruction follows
        i_req = 1; i_addr = 16'h0004; d_req = 1; d_we = 2'b00; d_addr = 16'h0010;
        step();
        d_req = 0;
        step();
        idle();
        step();

        // LED writes, then MMIO read together with a fetch
        d_req = 1; d_we = 2'b11; d_addr = 16'h0200; d_wdata = 16'hABCD;
        step();
        d_we = 2'b01; d_addr = 16'h0202; d_wdata = 16'h0077;
        step();
        chk("led_const", led, 24'h77ABCD);
        d_we = 2'b00; i_req = 1; i_addr = 16'h0002;
        step();
        idle();
        step();
        chk("mmio_rd_const", d_rdata, 16'h0077);

        // host starvation under continuous data traffic
        h_req = 1; h_we = 2'b00; h_addr = 16'hC004;
        d_req = 1; d_we = 2'b00; d_addr = 16'h0008;
        n = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            n++;
            seen = g_h;
        end
        chk("host_grant_cycle", n, 16);
        h_req = 0;
        step();
        h_req = 1; h_addr = 16'hC006;
        step();
        idle();
        step();

        // byte write to odd address, then read back
        d_req = 1; d_we = 2'b01; d_addr = 16'h0021; d_wdata = 16'h00EE;
        step();
        d_we = 2'b00; d_addr = 16'h0020;
        step();
        idle();
        step();
        chk("byte_lo", d_rdata[7:0], 8'hEE);

        // reset right after a host read grant
        h_req = 1; h_we = 2'b00; h_addr = 16'hC000;
        step();
        idle();
        rst = 1;
        i_req = 1; d_req = 1; d_we = 2'b11; d_addr = 16'h0200; d_wdata = 16'h5555;
        @(negedge clk);
        chk("rst_mid_h_rvalid", h_rvalid, 1'b0);
        chk("rst_mid_gnt", {i_gnt, d_gnt, h_gnt}, 3'b000);
        chk("rst_mid_m_en", m_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_led", led, 24'h0);
        chk("rst_mid_rdata", {i_rdata, d_rdata, h_rdata}, 48'h0);
        @(posedge clk); #1;
        rst = 0;
        idle();
        model_reset();
        step();

        // random traffic; a requester holds its request until granted
        g_i = 1; g_d = 1; g_h = 1;
        for (int t = 0; t < 400; t++) begin
            if (g_i || !i_req) begin
                i_req = ($urandom_range(0, 99) < 60);
                i_addr = rnd_addr();
            end
            if (g_d || !d_req) begin
                d_req = ($urandom_range(0, 99) < 50);
                d_addr = ($urandom_range(0, 3) == 0) ? 16'h0200 + 16'($urandom_range(0, 3)) : rnd_addr();
                d_we = 2'($urandom_range(0, 3));
                d_wdata = 16'($urandom);
            end
            if (g_h || !h_req) begin
                h_req = ($urandom_range(0, 99) < 40);
                h_addr = rnd_addr();
                h_we = 2'($urandom_range(0, 3));
                h_wdata = 16'($urandom);
            end
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
